debug_capture_bridge: RTL

DEBUG_CAPTURE_BRIDGE -- requirements
Module: debug_capture_bridge

---
 rtl/debug_pkg.sv | 23 ++
 rtl/debug_capture_ram.sv | 27 ++
 rtl/debug_capture_bridge.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared opcodes, response headers and FSM encodings for the MicroBlaze <-> MIPS debug path.
// Also imported by microblaze_mips_interface.
package debug_pkg;

   localparam logic [5:0] OpReqData = 6'b000011;
   localparam logic [5:0] OpGibData = 6'b100101;
   localparam logic [5:0] OpGotData = 6'b100100;
   localparam logic [5:0] OpCount   = 6'b001100;
   localparam logic [5:0] OpAbort   = 6'b111110;

   // Response frame headers; the low bits of OK/NOK frames are zero, IDLE is all-ones.
   localparam logic [5:0] HdrOk  = 6'b000011;
   localparam logic [5:0] HdrNok = 6'b000010;

   localparam logic [5:0] SelNone = 6'b111111;

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCapture = 2'd1;
   localparam logic [1:0] StReady   = 2'd2;

   typedef logic [5:0] opcode_t;

endpackage

// File: rtl/debug_capture_ram.sv
// Capture buffer: one write port, one synchronous read port, no reset on storage.
module debug_capture_ram #(
   parameter int unsigned NB_FRAME = 32,
   parameter int unsigned N_WORDS  = 8,
   localparam int unsigned AW      = $clog2(N_WORDS)
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [AW-1:0]       waddr_i,
   input  logic [NB_FRAME-1:0] wdata_i,
   input  logic [AW-1:0]       raddr_i,
   output logic [NB_FRAME-1:0] rdata_o
);

   logic [NB_FRAME-1:0] mem_q [N_WORDS];
   logic [NB_FRAME-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/debug_capture_bridge.sv
// Debug bridge: on MicroBlaze command, captures pipeline debug words into a buffer,
// then serves them back one frame per command.
module debug_capture_bridge
   import debug_pkg::*;
#(
   parameter int unsigned NB_FRAME  = 32,
   parameter int unsigned N_WORDS   = 8,
   parameter int unsigned NB_SELECT = 6
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic [NB_FRAME-1:0]  i_cmd,
   input  logic [NB_FRAME-1:0]  i_frame_from_mips,
   input  logic                 i_eod,
   output logic [NB_SELECT-1:0] o_request_select,
   output logic [NB_FRAME-1:0]  o_frame_to_blaze,
   output logic                 o_busy,
   output logic                 o_overflow
);

   localparam int unsigned AW = $clog2(N_WORDS);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] MaxCnt = CW'(N_WORDS);
   localparam logic [NB_FRAME-1:0] FrameOk  = {HdrOk, {(NB_FRAME-6){1'b0}}};
   localparam logic [NB_FRAME-1:0] FrameNok = {HdrNok, {(NB_FRAME-6){1'b0}}};

   logic [1:0]           state_q, state_d;
   logic [NB_SELECT-1:0] sel_q, sel_d;
   logic [CW-1:0]        wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]        rd_ptr_q, rd_ptr_d;
   logic                 ovf_q, ovf_d;
   logic [NB_FRAME-1:0]  frame_q, frame_d;
   logic                 valid_q;

   opcode_t             cmd_op;
   logic                cmd_valid;
   logic                cmd_fire;
   logic                abort_fire;
   logic                ram_we;
   logic [NB_FRAME-1:0] ram_rdata;
   logic                unused_cmd_bits;

   assign cmd_op          = i_cmd[NB_FRAME-1 -: 6];
   assign cmd_valid       = i_cmd[NB_FRAME-7];
   assign cmd_fire        = cmd_valid & ~valid_q;
   assign abort_fire      = cmd_fire && (cmd_op == OpAbort);
   assign unused_cmd_bits = ^i_cmd[NB_FRAME-8:NB_SELECT];

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      wr_cnt_d = wr_cnt_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      frame_d  = frame_q;
      ram_we   = 1'b0;

      if (cmd_fire) begin
         case (cmd_op)
            OpReqData: begin
               if (state_q == StIdle) begin
                  state_d  = StCapture;
                  sel_d    = i_cmd[NB_SELECT-1:0];
                  wr_cnt_d = '0;
                  rd_ptr_d = '0;
                  ovf_d    = 1'b0;
                  frame_d  = FrameOk;
               end else begin
                  frame_d = FrameNok;
               end
            end
            OpGibData: begin
               if (state_q == StReady && rd_ptr_q < wr_cnt_q) begin
                  frame_d  = ram_rdata;
                  rd_ptr_d = rd_ptr_q + CW'(1);
               end else begin
                  frame_d = FrameNok;
               end
            end
            OpGotData: begin
               if (state_q == StReady) begin
                  frame_d = (rd_ptr_q == wr_cnt_q) ? FrameOk : FrameNok;
                  state_d = StIdle;
               end else begin
                  frame_d = FrameNok;
               end
            end
            OpCount: begin
               frame_d = {OpCount, ovf_q, {(NB_FRAME-7-CW){1'b0}}, wr_cnt_q};
            end
            OpAbort: begin
               state_d  = StIdle;
               wr_cnt_d = '0;
               rd_ptr_d = '0;
               frame_d  = FrameOk;
            end
            default: frame_d = FrameNok;
         endcase
      end

      // An abort wins over the capture step of the same cycle.
      if (state_q == StCapture && !abort_fire) begin
         if (i_eod) begin
            state_d = StReady;
         end else if (wr_cnt_q < MaxCnt) begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + CW'(1);
         end else begin
            state_d = StReady;
            ovf_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= StIdle;
         sel_q    <= '1;
         wr_cnt_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         frame_q  <= '1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         wr_cnt_q <= wr_cnt_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         frame_q  <= frame_d;
         valid_q  <= cmd_valid;
      end
   end

   // Read address follows the next pointer so ram_rdata always holds buf[rd_ptr_q].
   debug_capture_ram #(
      .NB_FRAME (NB_FRAME),
      .N_WORDS  (N_WORDS)
   ) u_ram (
      .clk_i   (i_clock),
      .we_i    (ram_we),
      .waddr_i (wr_cnt_q[AW-1:0]),
      .wdata_i (i_frame_from_mips),
      .raddr_i (rd_ptr_d[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   assign o_busy           = (state_q == StCapture);
   assign o_request_select = o_busy ? sel_q : '1;
   assign o_frame_to_blaze = frame_q;
   assign o_overflow       = ovf_q;

endmodule
